// File: rtl/core_defines_pkg.sv
// Core-wide widths and the default fetch-queue depth, shared by the IF/ID blocks.
// The macros are defined once here; the package re-exports them as typed constants.
`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif
`ifndef CORE_FQ_DEPTH
`define CORE_FQ_DEPTH 4
`endif

package core_defines;
    localparam int PC_W     = `CORE_PC_WIDTH;
    localparam int INST_W   = `CORE_INST_WIDTH;
    localparam int FQ_DEPTH = `CORE_FQ_DEPTH;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              branch_predict;
    } fq_entry_t;
endpackage

// File: rtl/core_if_fq_mem.sv
// Fetch-queue payload storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the pointers in the top.
module core_if_fq_mem
    import core_defines::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fq_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output fq_entry_t     rdata
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/core_if_fetch_queue.sv
// IFU -> IDU fetch queue with valid/ready handshakes on both sides and a commit flush.
// Optional macro CORE_FQ_BYPASS_EN: an empty queue forwards the incoming entry combinationally.
module core_if_fetch_queue
    import core_defines::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [INST_W-1:0] i_inst,
    input  logic              i_branch_predict,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [PC_W-1:0]   o_pc,
    output logic [INST_W-1:0] o_inst,
    output logic              o_branch_predict,
    input  logic              i_pipe_flush_req,
    output logic [CNT_W-1:0]  o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    fq_entry_t        in_entry;
    fq_entry_t        head_entry;
    fq_entry_t        out_entry;

    assign in_entry = '{pc: i_pc, inst: i_inst, branch_predict: i_branch_predict};

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign ready_in = !rst && !full && !i_pipe_flush_req;

`ifdef CORE_FQ_BYPASS_EN
    logic bypass;

    assign bypass    = empty && !i_pipe_flush_req && !rst;
    assign valid_out = bypass ? valid_in : (!empty && !i_pipe_flush_req && !rst);
    assign out_entry = bypass ? in_entry : head_entry;
    // An entry consumed in the same cycle it arrives never touches the storage.
    assign push      = valid_in && ready_in && !(bypass && ready_out);
    assign pop       = valid_out && ready_out && !bypass;
`else
    assign valid_out = !empty && !i_pipe_flush_req && !rst;
    assign out_entry = head_entry;
    assign push      = valid_in && ready_in;
    assign pop       = valid_out && ready_out;
`endif

    assign o_pc             = out_entry.pc;
    assign o_inst           = out_entry.inst;
    assign o_branch_predict = out_entry.branch_predict;
    assign o_count          = count;

    always_ff @(posedge clk) begin
        if (rst || i_pipe_flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    core_if_fq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head_entry)
    );

endmodule

// File: tb/tb_core_if_fetch_queue.sv
// Self-checking bench for core_if_fetch_queue (DEPTH=4): directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_core_if_fetch_queue;
    import core_defines::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic              ready_in;
    logic [PC_W-1:0]   i_pc;
    logic [INST_W-1:0] i_inst;
    logic              i_branch_predict;
    logic              valid_out;
    logic              ready_out;
    logic [PC_W-1:0]   o_pc;
    logic [INST_W-1:0] o_inst;
    logic              o_branch_predict;
    logic              i_pipe_flush_req;
    logic [CNT_W-1:0]  o_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              bp;
    } ent_t;

    ent_t model_q[$];

    logic              obs_valid_out, obs_ready_in, obs_bp;
    logic [PC_W-1:0]   obs_pc;
    logic [INST_W-1:0] obs_inst;
    logic              exp_valid_out, exp_ready_in, exp_bp;
    logic [PC_W-1:0]   exp_pc;
    logic [INST_W-1:0] exp_inst;

    core_if_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .ready_in         (ready_in),
        .i_pc             (i_pc),
        .i_inst           (i_inst),
        .i_branch_predict (i_branch_predict),
        .valid_out        (valid_out),
        .ready_out        (ready_out),
        .o_pc             (o_pc),
        .o_inst           (o_inst),
        .o_branch_predict (o_branch_predict),
        .i_pipe_flush_req (i_pipe_flush_req),
        .o_count          (o_count)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, sample outputs at the falling edge, advance the model at the rising edge.
    task automatic tick(input logic r, input logic v, input logic [PC_W-1:0] pc,
                        input logic [INST_W-1:0] inst, input logic bp,
                        input logic ro, input logic fl);
        ent_t e;
        logic through;
        rst = r; valid_in = v; i_pc = pc; i_inst = inst; i_branch_predict = bp;
        ready_out = ro; i_pipe_flush_req = fl;
        @(negedge clk);
        obs_valid_out = valid_out; obs_ready_in = ready_in;
        obs_pc = o_pc; obs_inst = o_inst; obs_bp = o_branch_predict;
        through = 1'b0;
        exp_pc = '0; exp_inst = '0; exp_bp = 1'b0;
        if (r) begin
            exp_ready_in  = 1'b0;
            exp_valid_out = 1'b0;
        end else begin
            exp_ready_in = (model_q.size() < DEPTH) && !fl;
            if (model_q.size() > 0) begin
                exp_valid_out = !fl;
                exp_pc = model_q[0].pc; exp_inst = model_q[0].inst; exp_bp = model_q[0].bp;
            end else begin
`ifdef CORE_FQ_BYPASS_EN
                exp_valid_out = v && !fl;
                exp_pc = pc; exp_inst = inst; exp_bp = bp;
                through = v && !fl;
`else
                exp_valid_out = 1'b0;
`endif
            end
        end
        @(posedge clk);
        if (r || fl) begin
            model_q.delete();
        end else begin
            if (exp_valid_out && ro && !through) e = model_q.pop_front();
            if (v && exp_ready_in && !(through && ro)) begin
                e.pc = pc; e.inst = inst; e.bp = bp;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1, 1, 32'h1234, 32'h0, 0, 1, 0);
            checks++;
            if (obs_valid_out !== 1'b0 || obs_ready_in !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs: valid_out=%b ready_in=%b required 0/0", obs_valid_out, obs_ready_in);
            end
        end
        checks++;
        if (o_count !== '0) begin
            failures++;
            $display("FAIL reset_count: got %0d required 0", o_count);
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_ready_in !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b required 1", obs_ready_in);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            tick(0, 1, 32'h1000 + 32'(4 * i), 32'hA000 + 32'(i), i[0], 0, 0);
            checks++;
            if (obs_ready_in !== 1'b1 || o_count !== CNT_W'(i + 1)) begin
                failures++;
                $display("FAIL fill_push%0d: ready_in=%b count=%0d required 1/%0d", i, obs_ready_in, o_count, i + 1);
            end
        end
        tick(0, 1, 32'h2000, 32'hBEEF, 1, 0, 0);
        checks++;
        if (obs_ready_in !== 1'b0 || o_count !== CNT_W'(DEPTH)) begin
            failures++;
            $display("FAIL fill_fifth_rejected: ready_in=%b count=%0d required 0/%0d", obs_ready_in, o_count, DEPTH);
        end
        checks++;
        if (obs_valid_out !== 1'b1 || obs_pc !== 32'h1000 || obs_inst !== 32'hA000) begin
            failures++;
            $display("FAIL fill_head_stable: valid=%b pc=%h inst=%h required 1/00001000/0000a000", obs_valid_out, obs_pc, obs_inst);
        end
    endtask

    task automatic test_full_pop();
        tick(0, 1, 32'h3000, 32'h3, 0, 1, 0);
        checks++;
        if (obs_ready_in !== 1'b0 || obs_valid_out !== 1'b1 || obs_pc !== 32'h1000) begin
            failures++;
            $display("FAIL full_pop_cycle: ready_in=%b valid=%b pc=%h required 0/1/00001000", obs_ready_in, obs_valid_out, obs_pc);
        end
        checks++;
        if (o_count !== CNT_W'(3)) begin
            failures++;
            $display("FAIL full_pop_count: got %0d required 3", o_count);
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_ready_in !== 1'b1 || obs_pc !== 32'h1004 || obs_bp !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_next: ready_in=%b pc=%h bp=%b required 1/00001004/1", obs_ready_in, obs_pc, obs_bp);
        end
    endtask

    task automatic test_stream();
        int k_in = 0;
        int k_out = 0;
        tick(0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 30; c++) begin
            tick(0, k_in < 10, 32'h8000_0000 + 32'(4 * k_in), 32'(k_in), 0, 1, 0);
            if (obs_ready_in && k_in < 10) k_in++;
            if (obs_valid_out) begin
                checks++;
                if (obs_pc !== 32'h8000_0000 + 32'(4 * k_out)) begin
                    failures++;
                    $display("FAIL stream_order%0d: got %h required %h", k_out, obs_pc, 32'h8000_0000 + 32'(4 * k_out));
                end
                k_out++;
            end
        end
        checks++;
        if (k_out !== 10 || o_count !== '0) begin
            failures++;
            $display("FAIL stream_total: popped=%0d count=%0d required 10/0", k_out, o_count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) tick(0, 1, 32'h4000 + 32'(4 * i), 32'h0, 0, 0, 0);
        tick(0, 1, 32'hDEAD_BEE0, 32'hDEAD, 1, 1, 1);
        checks++;
        if (obs_valid_out !== 1'b0 || obs_ready_in !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle: valid=%b ready_in=%b required 0/0", obs_valid_out, obs_ready_in);
        end
        checks++;
        if (o_count !== '0) begin
            failures++;
            $display("FAIL flush_count: got %0d required 0", o_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0, 1, 0);
            checks++;
            if (obs_valid_out !== 1'b0) begin
                failures++;
                $display("FAIL flush_no_leak: valid=%b pc=%h required valid 0", obs_valid_out, obs_pc);
            end
        end
    endtask

    task automatic test_bypass();
        tick(0, 1, 32'h8000_0010, 32'h1313, 1, 1, 0);
`ifdef CORE_FQ_BYPASS_EN
        checks++;
        if (obs_valid_out !== 1'b1 || obs_pc !== 32'h8000_0010 || o_count !== '0) begin
            failures++;
            $display("FAIL bypass_same_cycle: valid=%b pc=%h count=%0d required 1/80000010/0", obs_valid_out, obs_pc, o_count);
        end
`else
        checks++;
        if (obs_valid_out !== 1'b0 || o_count !== CNT_W'(1)) begin
            failures++;
            $display("FAIL nobypass_first: valid=%b count=%0d required 0/1", obs_valid_out, o_count);
        end
        tick(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (obs_valid_out !== 1'b1 || obs_pc !== 32'h8000_0010 || obs_bp !== 1'b1) begin
            failures++;
            $display("FAIL nobypass_latency: valid=%b pc=%h bp=%b required 1/80000010/1", obs_valid_out, obs_pc, obs_bp);
        end
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) tick(0, 1, 32'h5000 + 32'(4 * i), 32'h0, 0, 0, 0);
        tick(1, 1, 32'h6000, 32'h0, 0, 1, 0);
        checks++;
        if (obs_valid_out !== 1'b0 || obs_ready_in !== 1'b0 || o_count !== '0) begin
            failures++;
            $display("FAIL reset_mid: valid=%b ready_in=%b count=%0d required 0/0/0", obs_valid_out, obs_ready_in, o_count);
        end
        tick(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (obs_ready_in !== 1'b1 || obs_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_release: ready_in=%b valid=%b required 1/0", obs_ready_in, obs_valid_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            checks++;
            if (obs_valid_out !== exp_valid_out || obs_ready_in !== exp_ready_in) begin
                failures++;
                $display("FAIL rand_handshake@%0d: valid=%b ready_in=%b required %b/%b", c, obs_valid_out, obs_ready_in, exp_valid_out, exp_ready_in);
            end
            if (exp_valid_out) begin
                checks++;
                if (obs_pc !== exp_pc || obs_inst !== exp_inst || obs_bp !== exp_bp) begin
                    failures++;
                    $display("FAIL rand_payload@%0d: got %h/%h/%b required %h/%h/%b", c, obs_pc, obs_inst, obs_bp, exp_pc, exp_inst, exp_bp);
                end
            end
            checks++;
            if (o_count !== CNT_W'(model_q.size())) begin
                failures++;
                $display("FAIL rand_count@%0d: got %0d required %0d", c, o_count, model_q.size());
            end
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; i_pc = '0; i_inst = '0; i_branch_predict = 1'b0;
        ready_out = 1'b0; i_pipe_flush_req = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_full_pop();
        test_stream();
        test_flush();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
